// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round scheduler.
//   state_t   : controller states
//   sat_add8  : 8-bit add that saturates at 255
//   W         : timer / rng width, $clog2 of the default 2047 ms timer range
package mole_pkg;

   localparam int MAX_MS_DEF = 2047;
   localparam int W          = $clog2(MAX_MS_DEF);

   typedef enum logic [2:0] {IDLE, GAP, UP, FLASH, DONE} state_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/mole_round_scheduler_mole_select.sv
// Picks the next mole position and holds it for the rest of the round.
// The candidate is random_value % NUM_MOLES; when it equals the previous
// position it is bumped to the next mole (wrapping), so the same mole never
// comes up twice in a row. The held position clears to 0 on reset.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   random_value  : free-running rng value
//   latch         : 1-cycle strobe, captures the new position
//   pos           : currently held mole position
module mole_select
   import mole_pkg::*;
#(
   parameter int NUM_MOLES = 4,
   parameter int PW        = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [W-1:0]  random_value,
   input  logic          latch,
   output logic [PW-1:0] pos
);

   logic [PW-1:0] cand;
   logic [PW-1:0] pick;

   always_comb begin
      cand = PW'(random_value % W'(NUM_MOLES));
      pick = cand;
      if (cand == pos) begin
         pick = (cand == PW'(NUM_MOLES - 1)) ? '0 : cand + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos <= '0;
      end else if (latch) begin
         pos <= pick;
      end
   end

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole game controller. Runs one game of ROUNDS rounds: random gap,
// one random mole lit for the up-time, then score (correct key) or miss
// (wrong key or timeout). Drives the shared down-counting ms timer.
// Optional feature macro: MOLE_SPEEDUP_EN -- up-time starts at UP_MS and drops
// by SPEEDUP_STEP each round end, floored at MIN_UP_MS. Without it the up-time
// is the constant UP_MS.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : 1-cycle pulse, starts a game (IDLE or DONE only)
//   hit            : 1-cycle debounced key pulses, bit i = mole i
//   random_value   : free-running rng value
//   timer_value    : down-counting timer value
//   timer_reset    : 1-cycle load pulse, timer_start valid alongside
//   timer_start    : timer load value
//   timer_enable   : timer counts while high (GAP, UP, FLASH)
//   mole_led       : one-hot lit mole or 0
//   score, misses  : saturating 8-bit counters for this game
//   rounds_left    : rounds still to play
//   game_over      : high in DONE
// W comes from mole_pkg; MAX_MS should stay consistent with it.
module mole_round_scheduler
   import mole_pkg::*;
#(
   parameter int MAX_MS       = MAX_MS_DEF,
   parameter int NUM_MOLES    = 4,
   parameter int ROUNDS       = 16,
   parameter int UP_MS        = 1000,
   parameter int MIN_GAP_MS   = 200,
   parameter int FLASH_MS     = 250
`ifdef MOLE_SPEEDUP_EN
   ,parameter int SPEEDUP_STEP = 50,
   parameter int MIN_UP_MS    = 300
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] hit,
   input  logic [W-1:0]         random_value,
   input  logic [W-1:0]         timer_value,
   output logic                 timer_reset,
   output logic [W-1:0]         timer_start,
   output logic                 timer_enable,
   output logic [NUM_MOLES-1:0] mole_led,
   output logic [7:0]           score,
   output logic [7:0]           misses,
   output logic [7:0]           rounds_left,
   output logic                 game_over
);

   localparam int PW = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1;

   state_t               state, state_nx;
   logic [7:0]           score_nx, misses_nx, rounds_nx;
   logic                 load_nx;
   logic [W-1:0]         start_nx;
   logic                 armed;
   logic                 latch_pos;
   logic                 restart;
   logic                 end_round;
   logic [PW-1:0]        pos;
   logic [NUM_MOLES-1:0] pos_mask;
   logic                 correct, wrong, expiry;
   logic [W:0]           gap_sum;
   logic [W-1:0]         gap_ms;
   logic [W-1:0]         up_time;

   mole_select #(
      .NUM_MOLES (NUM_MOLES),
      .PW        (PW)
   ) u_select (
      .clk          (clk),
      .reset_n      (reset_n),
      .random_value (random_value),
      .latch        (latch_pos),
      .pos          (pos)
   );

   // Gap = MIN_GAP_MS + random_value[W-2:0], clamped to the timer range.
   always_comb begin
      gap_sum = (W+1)'(MIN_GAP_MS) + {2'b00, random_value[W-2:0]};
      gap_ms  = (gap_sum > (W+1)'(MAX_MS)) ? W'(MAX_MS) : gap_sum[W-1:0];
   end

`ifdef MOLE_SPEEDUP_EN
   logic [W-1:0] up_ms, up_ms_nx;

   // Compare before subtracting so the up-time never wraps below the floor.
   always_comb begin
      up_ms_nx = up_ms;
      if (restart) begin
         up_ms_nx = W'(UP_MS);
      end else if (end_round) begin
         up_ms_nx = (up_ms >= W'(MIN_UP_MS + SPEEDUP_STEP)) ?
                    up_ms - W'(SPEEDUP_STEP) : W'(MIN_UP_MS);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         up_ms <= W'(UP_MS);
      end else begin
         up_ms <= up_ms_nx;
      end
   end

   assign up_time = up_ms;
`else
   assign up_time = W'(UP_MS);
`endif

   assign pos_mask     = NUM_MOLES'(1) << pos;
   assign correct      = |(hit & pos_mask);
   assign wrong        = |(hit & ~pos_mask);
   assign timer_enable = (state == GAP) || (state == UP) || (state == FLASH);
   assign mole_led     = ((state == UP) || (state == FLASH)) ? pos_mask : '0;
   assign game_over    = (state == DONE);

   // timer_value is stale while the load pulse is out and in the cycle after
   // it (armed), so a leftover 0 from the previous phase is not an expiry.
   assign expiry = (timer_value == '0) && timer_enable && !armed && !timer_reset;

   always_comb begin
      state_nx  = state;
      score_nx  = score;
      misses_nx = misses;
      rounds_nx = rounds_left;
      load_nx   = 1'b0;
      start_nx  = '0;
      latch_pos = 1'b0;
      restart   = 1'b0;
      end_round = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               restart   = 1'b1;
               score_nx  = 8'd0;
               misses_nx = 8'd0;
               rounds_nx = 8'(ROUNDS);
               load_nx   = 1'b1;
               start_nx  = gap_ms;
               state_nx  = GAP;
            end
         end
         GAP: begin
            if (expiry) begin
               latch_pos = 1'b1;
               load_nx   = 1'b1;
               start_nx  = up_time;
               state_nx  = UP;
            end
         end
         UP: begin
            // A clean correct hit wins even in the expiry cycle; any wrong key
            // turns the press into a miss.
            if (correct && !wrong) begin
               score_nx = sat_add8(score, 8'd1);
               load_nx  = 1'b1;
               start_nx = W'(FLASH_MS);
               state_nx = FLASH;
            end else if (wrong || expiry) begin
               misses_nx = sat_add8(misses, 8'd1);
               end_round = 1'b1;
            end
         end
         FLASH: begin
            if (expiry) begin
               end_round = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (end_round) begin
         rounds_nx = rounds_left - 8'd1;
         if (rounds_nx == 8'd0) begin
            state_nx = DONE;
         end else begin
            load_nx  = 1'b1;
            start_nx = gap_ms;
            state_nx = GAP;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         score       <= 8'd0;
         misses      <= 8'd0;
         rounds_left <= 8'd0;
         timer_reset <= 1'b0;
         timer_start <= '0;
         armed       <= 1'b0;
      end else begin
         state       <= state_nx;
         score       <= score_nx;
         misses      <= misses_nx;
         rounds_left <= rounds_nx;
         timer_reset <= load_nx;
         timer_start <= start_nx;
         armed       <= timer_reset;
      end
   end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with a 1-cycle-per-ms timer model.
module tb_mole_round_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  hit;
   logic [10:0] random_value;
   logic [10:0] timer_value;
   logic        timer_reset;
   logic [10:0] timer_start;
   logic        timer_enable;
   logic [3:0]  mole_led;
   logic [7:0]  score;
   logic [7:0]  misses;
   logic [7:0]  rounds_left;
   logic        game_over;

   logic [10:0] tval;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mole_round_scheduler dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .hit          (hit),
      .random_value (random_value),
      .timer_value  (timer_value),
      .timer_reset  (timer_reset),
      .timer_start  (timer_start),
      .timer_enable (timer_enable),
      .mole_led     (mole_led),
      .score        (score),
      .misses       (misses),
      .rounds_left  (rounds_left),
      .game_over    (game_over)
   );

   // Down-counting timer: loads on the edge after timer_reset, one ms per cycle.
   assign timer_value = tval;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        tval <= '0;
      else if (timer_reset)                tval <= timer_start;
      else if (timer_enable && tval != 0)  tval <= tval - 11'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_lit(input bit want, input int budget, input string tag);
      int n = 0;
      while (((mole_led != 0) != want) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'((mole_led != 0) == want), 32'd1);
   endtask

   function automatic int exp_up(input int r);
      int v;
`ifdef MOLE_SPEEDUP_EN
      v = 1000 - 50 * (r - 1);
      if (v < 300) v = 300;
`else
      v = 1000 + 0 * r;
`endif
      return v;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_led"},    32'(mole_led),     0);
      chk({tag, "_score"},  32'(score),        0);
      chk({tag, "_misses"}, 32'(misses),       0);
      chk({tag, "_rounds"}, 32'(rounds_left),  0);
      chk({tag, "_over"},   32'(game_over),    0);
      chk({tag, "_treset"}, 32'(timer_reset),  0);
      chk({tag, "_ten"},    32'(timer_enable), 0);
      chk({tag, "_tstart"}, 32'(timer_start),  0);
   endtask

   initial begin
      int n;
      logic [3:0] prev_led;

      reset_n = 1'b0; start = 1'b0; hit = '0; random_value = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");

      reset_n = 1'b1;
      @(negedge clk);

      // Round 1: gap 200+5, pos 5%4=1 -> LED 0010, correct hit.
      random_value = 11'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_treset", 32'(timer_reset), 1);
      chk("start_tstart", 32'(timer_start), 205);
      chk("start_rounds", 32'(rounds_left), 16);
      chk("start_ten",    32'(timer_enable), 1);
      chk("gap_led",      32'(mole_led), 0);
      wait_lit(1'b1, 300, "r1_lit");
      chk("r1_timer_zero", 32'(tval), 0);
      chk("r1_led",        32'(mole_led), 4'b0010);
      chk("r1_up",         32'(timer_start), exp_up(1));
      chk("r1_treset",     32'(timer_reset), 1);
      hit = 4'b0010;
      @(negedge clk);
      hit = '0;
      chk("r1_score",       32'(score), 1);
      chk("r1_flash_start", 32'(timer_start), 250);
      chk("r1_flash_led",   32'(mole_led), 4'b0010);

      // Round 2: gap 202, pos 2 -> wrong+correct keys count as a miss.
      random_value = 11'd2;
      wait_lit(1'b0, 300, "r1_end");
      chk("r1_rounds", 32'(rounds_left), 15);
      chk("r2_gap",    32'(timer_start), 202);
      wait_lit(1'b1, 300, "r2_lit");
      chk("r2_led", 32'(mole_led), 4'b0100);
      hit = 4'b0110;
      @(negedge clk);
      hit = '0;
      chk("r2_miss",      32'(misses), 1);
      chk("r2_led_off",   32'(mole_led), 0);
      chk("r2_score",     32'(score), 1);
      chk("r2_gap_load",  32'(timer_start), 202);
      chk("r2_rounds",    32'(rounds_left), 14);

      // Round 3: rng repeats 2 -> bumped to 3; left unhit -> timeout miss.
      wait_lit(1'b1, 300, "r3_lit");
      chk("r3_no_repeat", 32'(mole_led), 4'b1000);
      wait_lit(1'b0, 1100, "r3_expire");
      chk("r3_misses", 32'(misses), 2);
      chk("r3_score",  32'(score), 1);
      chk("r3_rounds", 32'(rounds_left), 13);

      // Keys in GAP are ignored.
      hit = 4'b1111; random_value = 11'd6;
      @(negedge clk);
      hit = '0;
      chk("gap_hit_score",  32'(score), 1);
      chk("gap_hit_misses", 32'(misses), 2);

      // Round 4: pos 6%4=2, correct hit exactly in the expiry cycle.
      n = 0;
      while (!(mole_led != 0 && !timer_reset && tval == 0) && n < 1400) begin
         @(negedge clk);
         n++;
      end
      chk("r4_reach_expiry", 32'(mole_led != 0 && !timer_reset && tval == 0), 1);
      chk("r4_led", 32'(mole_led), 4'b0100);
      hit = 4'b0100;
      @(negedge clk);
      hit = '0;
      chk("r4_expiry_hit_score", 32'(score), 2);
      chk("r4_expiry_misses",    32'(misses), 2);
      chk("r4_flash_start",      32'(timer_start), 250);
      chk("r4_flash_led",        32'(mole_led), 4'b0100);

      // Keys and start in FLASH are ignored.
      hit = 4'b0100; start = 1'b1;
      @(negedge clk);
      hit = '0; start = 1'b0;
      chk("flash_hit_score", 32'(score), 2);
      chk("flash_start_rnd", 32'(rounds_left), 13);
      chk("flash_no_load",   32'(timer_reset), 0);

      random_value = 11'd0;
      wait_lit(1'b0, 300, "r4_end");
      chk("r4_rounds", 32'(rounds_left), 12);

      // Rounds 5..16: hit every mole straight away.
      prev_led = 4'b0100;
      for (int r = 5; r <= 16; r++) begin
         wait_lit(1'b1, 300, "loop_lit");
         chk("loop_up_time",  32'(timer_start), exp_up(r));
         chk("loop_no_repeat", 32'(mole_led == prev_led), 0);
         prev_led = mole_led;
         hit = mole_led;
         @(negedge clk);
         hit = '0;
         chk("loop_score", 32'(score), 32'(r - 2));
         wait_lit(1'b0, 300, "loop_end");
      end
      chk("done_over",   32'(game_over), 1);
      chk("done_rounds", 32'(rounds_left), 0);
      chk("done_score",  32'(score), 14);
      chk("done_misses", 32'(misses), 2);
      chk("done_ten",    32'(timer_enable), 0);

      // Restart from DONE.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_score",  32'(score), 0);
      chk("restart_misses", 32'(misses), 0);
      chk("restart_rounds", 32'(rounds_left), 16);
      chk("restart_over",   32'(game_over), 0);
      chk("restart_treset", 32'(timer_reset), 1);
      chk("restart_tstart", 32'(timer_start), 200);

      // Asynchronous reset in the middle of UP.
      wait_lit(1'b1, 300, "mid_lit");
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_led", 32'(mole_led), 0);
      chk("post_reset_ten", 32'(timer_enable), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case a wait loop is ever bypassed.
   initial begin
      #2000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
